// File: rtl/pix_ctrl_pkg.sv
// Shared types and pixel-format helpers for the RGB frame SRAM burst controller.
// Helpers take the pixel width as an argument; widths up to GREY_MAX_W are supported.
package pix_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_t;

  localparam int GREY_MAX_W = 16;

  // grey = (R + 2G + B) >> 2, summed two bits wider than a pixel so nothing overflows
  function automatic logic [GREY_MAX_W-1:0] rgb_to_grey(input logic [3*GREY_MAX_W-1:0] rgb,
                                                        input int unsigned pix_w);
    logic [GREY_MAX_W+1:0] mask;
    logic [GREY_MAX_W+1:0] r;
    logic [GREY_MAX_W+1:0] g;
    logic [GREY_MAX_W+1:0] b;
    logic [GREY_MAX_W+1:0] sum;
    mask = {(GREY_MAX_W+2){1'b1}} >> (GREY_MAX_W + 2 - pix_w);
    r    = (GREY_MAX_W+2)'(rgb >> (2 * pix_w)) & mask;
    g    = (GREY_MAX_W+2)'(rgb >> pix_w) & mask;
    b    = (GREY_MAX_W+2)'(rgb) & mask;
    sum  = r + (g << 1) + b;
    return GREY_MAX_W'(sum >> 2);
  endfunction

  function automatic logic [3*GREY_MAX_W-1:0] grey_to_rgb(input logic [GREY_MAX_W-1:0] p,
                                                          input int unsigned pix_w);
    logic [3*GREY_MAX_W-1:0] mask;
    logic [3*GREY_MAX_W-1:0] pm;
    mask = {(3*GREY_MAX_W){1'b1}} >> (3 * GREY_MAX_W - pix_w);
    pm   = (3*GREY_MAX_W)'(p) & mask;
    return pm | (pm << pix_w) | (pm << (2 * pix_w));
  endfunction

endpackage

// File: rtl/sync_flex_counter.sv
// Wrapping counter with synchronous clear; rollover_flag marks the terminal count.
module sync_flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  assign rollover_flag = (count_out == rollover_val);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      if (rollover_flag) count_out <= '0;
      else               count_out <= count_out + NUM_CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/pixel_burst_ctrl.sv
// Burst controller between the edge-detection window and the 24-bit RGB frame SRAM:
// reads convert to greyscale, writes expand grey to RGB, each access held WAIT_CYC cycles.
module pixel_burst_ctrl
  import pix_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int PIX_W    = 8,
  parameter int MAX_PIX  = 20,
  parameter int CNT_W    = 5,
  parameter int WAIT_CYC = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           op,
  input  logic [ADDR_W-1:0]              base_addr,
  input  logic [CNT_W-1:0]               num_pix,
  input  logic [MAX_PIX-1:0][PIX_W-1:0]  pix_in,
  output logic [MAX_PIX-1:0][PIX_W-1:0]  pix_out,
  output logic                           busy,
  output logic                           done,
  output logic [ADDR_W-1:0]              sram_addr,
  output logic [3*PIX_W-1:0]             sram_wdata,
  input  logic [3*PIX_W-1:0]             sram_rdata,
  output logic                           sram_re,
  output logic                           sram_we
);

  localparam int IDX_W = (MAX_PIX > 1) ? $clog2(MAX_PIX) : 1;
  localparam int W_W   = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [W_W-1:0]    W_LAST  = W_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [IDX_W-1:0]  IDX_ONE = IDX_W'(1);
  localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);

  state_t                         state;
  op_t                            op_lat;
  logic [CNT_W-1:0]               n_lat;
  logic [IDX_W-1:0]               i;
  logic [MAX_PIX-1:0][PIX_W-1:0]  pix_lat;
  logic [W_W-1:0]                 w;
  logic                           w_roll;
  logic [CNT_W-1:0]               n_req;
  logic [PIX_W-1:0]               grey;

  assign n_req = (num_pix > CNT_W'(MAX_PIX)) ? CNT_W'(MAX_PIX) : num_pix;
  assign grey  = PIX_W'(rgb_to_grey((3*GREY_MAX_W)'(sram_rdata), PIX_W));

  // Wait counter free-runs only in ACCESS, so every pixel starts from w = 0
  sync_flex_counter #(
    .NUM_CNT_BITS (W_W)
  ) u_wait_cnt (
    .clk           (clk),
    .rst           (rst),
    .clear         (state != ACCESS),
    .count_enable  (state == ACCESS),
    .rollover_val  (W_LAST),
    .count_out     (w),
    .rollover_flag (w_roll)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_lat     <= OP_READ;
      n_lat      <= '0;
      i          <= '0;
      pix_lat    <= '0;
      pix_out    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_re    <= 1'b0;
      sram_we    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_lat    <= op_t'(op);
            n_lat     <= n_req;
            pix_lat   <= pix_in;
            i         <= '0;
            sram_addr <= base_addr;
            if (n_req == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= ACCESS;
              busy       <= 1'b1;
              sram_re    <= (op_t'(op) == OP_READ);
              sram_we    <= (op_t'(op) == OP_WRITE);
              sram_wdata <= (op_t'(op) == OP_WRITE) ?
                            (3*PIX_W)'(grey_to_rgb(GREY_MAX_W'(pix_in[0]), PIX_W)) : '0;
            end
          end
        end
        ACCESS: begin
          if (op_lat == OP_READ && w == W_LAST) pix_out[i] <= grey;
          // Address and write data advance together once the hold time has elapsed
          if (w_roll) begin
            if (CNT_W'(i) + CNT_ONE == n_lat) begin
              state      <= DONE;
              done       <= 1'b1;
              busy       <= 1'b0;
              sram_re    <= 1'b0;
              sram_we    <= 1'b0;
              sram_wdata <= '0;
            end else begin
              i         <= i + IDX_ONE;
              sram_addr <= sram_addr + ADR_ONE;
              if (op_lat == OP_WRITE)
                sram_wdata <= (3*PIX_W)'(grey_to_rgb(GREY_MAX_W'(pix_lat[i + IDX_ONE]), PIX_W));
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_burst_ctrl.sv
// Randomised self-checking bench for pixel_burst_ctrl with a cycle-level burst reference model.
module tb_pixel_burst_ctrl;

  localparam int ADDR_W   = 16;
  localparam int PIX_W    = 8;
  localparam int MAX_PIX  = 20;
  localparam int CNT_W    = 5;
  localparam int WAIT_CYC = 3;

  logic                          clk;
  logic                          rst;
  logic                          start;
  logic                          op;
  logic [ADDR_W-1:0]             base_addr;
  logic [CNT_W-1:0]              num_pix;
  logic [MAX_PIX-1:0][PIX_W-1:0] pix_in;
  logic [MAX_PIX-1:0][PIX_W-1:0] pix_out;
  logic                          busy;
  logic                          done;
  logic [ADDR_W-1:0]             sram_addr;
  logic [3*PIX_W-1:0]            sram_wdata;
  logic [3*PIX_W-1:0]            sram_rdata;
  logic                          sram_re;
  logic                          sram_we;

  int unsigned n_compared   = 0;
  int unsigned n_mismatched = 0;

  int                            rd_mode;
  logic [23:0]                   rd_const;
  logic [23:0]                   rd_key;
  logic [MAX_PIX-1:0][PIX_W-1:0] exp_pix_out;

  pixel_burst_ctrl #(
    .ADDR_W   (ADDR_W),
    .PIX_W    (PIX_W),
    .MAX_PIX  (MAX_PIX),
    .CNT_W    (CNT_W),
    .WAIT_CYC (WAIT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .base_addr  (base_addr),
    .num_pix    (num_pix),
    .pix_in     (pix_in),
    .pix_out    (pix_out),
    .busy       (busy),
    .done       (done),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_re    (sram_re),
    .sram_we    (sram_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM read data as a pure function of address: plan pattern, constant, or keyed hash
  function automatic logic [23:0] rd_model(input logic [15:0] a, input int mode,
                                           input logic [23:0] cval, input logic [23:0] key);
    logic [7:0] lo;
    logic [7:0] hi;
    lo = a[7:0];
    hi = a[15:8];
    if (mode == 0) return {8'h10 + lo, 8'h20 + lo, 8'h30 + lo};
    if (mode == 1) return cval;
    return {lo ^ key[23:16], hi ^ key[15:8], (lo + hi) ^ key[7:0]};
  endfunction

  assign sram_rdata = rd_model(sram_addr, rd_mode, rd_const, rd_key);

  function automatic logic [7:0] grey_model(input logic [23:0] rgb);
    int r;
    int g;
    int b;
    r = int'(rgb[23:16]);
    g = int'(rgb[15:8]);
    b = int'(rgb[7:0]);
    return 8'((r + 2 * g + b) / 4);
  endfunction

  function automatic logic [159:0] pack_ctl(input logic b, input logic d, input logic r,
                                            input logic w, input logic [15:0] a,
                                            input logic [23:0] wd);
    return {116'b0, b, d, r, w, a, wd};
  endfunction

  task automatic checkOutput(input string tag, input logic [159:0] observed,
                             input logic [159:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Launch one burst at the current negedge (DUT in IDLE) and check every cycle through done
  task automatic applyStimulus(input logic op_v, input logic [15:0] base_v,
                               input logic [4:0] num_v,
                               input logic [MAX_PIX-1:0][PIX_W-1:0] pix_v,
                               input bit noise, input bit hold, input int abort_c);
    int          n_eff;
    int          last_c;
    int          j;
    int          completed;
    logic [15:0] a;
    logic [23:0] wd;
    n_eff  = (int'(num_v) > MAX_PIX) ? MAX_PIX : int'(num_v);
    last_c = n_eff * WAIT_CYC + 1;
    start     = 1'b1;
    op        = op_v;
    base_addr = base_v;
    num_pix   = num_v;
    pix_in    = pix_v;
    @(posedge clk);
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      completed = (c - 1) / WAIT_CYC;
      if (c < last_c) begin
        j  = (c - 1) / WAIT_CYC;
        a  = base_v + 16'(j);
        wd = op_v ? {3{pix_v[j]}} : 24'h0;
        checkOutput($sformatf("ctl c%0d", c),
                    pack_ctl(busy, done, sram_re, sram_we, sram_addr, sram_wdata),
                    pack_ctl(1'b1, 1'b0, !op_v, op_v, a, wd));
      end else begin
        checkOutput("done_cycle", pack_ctl(busy, done, sram_re, sram_we, 16'h0, 24'h0),
                    pack_ctl(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 24'h0));
      end
      if (!op_v) begin
        for (int k = 0; k < completed; k++)
          exp_pix_out[k] = grey_model(rd_model(base_v + 16'(k), rd_mode, rd_const, rd_key));
      end
      checkOutput($sformatf("pix_out c%0d", c), 160'(pix_out), 160'(exp_pix_out));
      if (c == abort_c) return;
      if (c == last_c) begin
        start = hold;
      end else if (noise) begin
        start     = 1'($urandom);
        op        = 1'($urandom);
        base_addr = 16'($urandom);
        num_pix   = 5'($urandom);
        for (int k = 0; k < MAX_PIX; k++) pix_in[k] = 8'($urandom);
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic idleCheck(input string tag);
    @(negedge clk);
    checkOutput(tag, pack_ctl(busy, done, sram_re, sram_we, 16'h0, 24'h0), 160'h0);
  endtask

  function automatic logic [MAX_PIX-1:0][PIX_W-1:0] rand_pix();
    logic [MAX_PIX-1:0][PIX_W-1:0] p;
    for (int k = 0; k < MAX_PIX; k++) p[k] = 8'($urandom);
    return p;
  endfunction

  initial begin
    logic [MAX_PIX-1:0][PIX_W-1:0] pv;
    logic [15:0]                   ba;
    logic [4:0]                    nv;

    rst = 1'b1; start = 1'b0; op = 1'b0; base_addr = '0; num_pix = '0; pix_in = '0;
    rd_mode = 0; rd_const = 24'h0; rd_key = 24'($urandom);
    exp_pix_out = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ctl", pack_ctl(busy, done, sram_re, sram_we, sram_addr, sram_wdata), 160'h0);
    checkOutput("reset_pix_out", 160'(pix_out), 160'h0);
    rst = 1'b0;
    idleCheck("idle_after_reset");

    $display("[TB] read 4 pixels at 0x0100");
    applyStimulus(1'b0, 16'h0100, 5'd4, '0, 1'b0, 1'b0, 0);
    checkOutput("plan_pix0", 160'(pix_out[0]), 160'(8'h20));
    idleCheck("idle_a");

    $display("[TB] write 3 pixels wrapping past 0xFFFF");
    pv = '0; pv[0] = 8'hAA; pv[1] = 8'h55; pv[2] = 8'hFF;
    applyStimulus(1'b1, 16'hFFFE, 5'd3, pv, 1'b0, 1'b0, 0);
    idleCheck("idle_b");

    $display("[TB] zero-length and over-length bursts");
    applyStimulus(1'b0, 16'h1234, 5'd0, rand_pix(), 1'b0, 1'b0, 0);
    idleCheck("idle_c");
    rd_mode = 2;
    applyStimulus(1'b0, 16'hFFF8, 5'd31, rand_pix(), 1'b0, 1'b0, 0);
    idleCheck("idle_d");
    applyStimulus(1'b1, 16'h0040, 5'd31, rand_pix(), 1'b1, 1'b0, 0);
    idleCheck("idle_e");

    $display("[TB] grey extremes");
    rd_mode = 1;
    rd_const = 24'hFFFFFF;
    applyStimulus(1'b0, 16'h0010, 5'd1, '0, 1'b0, 1'b0, 0);
    checkOutput("grey_ffffff", 160'(pix_out[0]), 160'(8'hFF));
    idleCheck("idle_f");
    rd_const = 24'h000000;
    applyStimulus(1'b0, 16'h0010, 5'd1, '0, 1'b0, 1'b0, 0);
    checkOutput("grey_000000", 160'(pix_out[0]), 160'(8'h00));
    idleCheck("idle_g");
    rd_const = 24'hFF0000;
    applyStimulus(1'b0, 16'h0010, 5'd1, '0, 1'b0, 1'b0, 0);
    checkOutput("grey_ff0000", 160'(pix_out[0]), 160'(8'h3F));
    idleCheck("idle_h");

    $display("[TB] start held high: back-to-back bursts");
    rd_mode = 2;
    pv = rand_pix();
    applyStimulus(1'b0, 16'h2000, 5'd2, pv, 1'b0, 1'b1, 0);
    idleCheck("b2b_gap");
    applyStimulus(1'b0, 16'h2000, 5'd2, pv, 1'b0, 1'b0, 0);
    idleCheck("idle_i");

    $display("[TB] reset during second pixel of a read");
    applyStimulus(1'b0, 16'h3000, 5'd5, '0, 1'b0, 1'b0, WAIT_CYC + 2);
    rst = 1'b1;
    exp_pix_out = '0;
    @(negedge clk);
    checkOutput("midrst_ctl", pack_ctl(busy, done, sram_re, sram_we, sram_addr, sram_wdata), 160'h0);
    checkOutput("midrst_pix_out", 160'(pix_out), 160'h0);
    rst = 1'b0;
    idleCheck("idle_after_midrst");
    applyStimulus(1'b0, 16'h3000, 5'd5, '0, 1'b0, 1'b0, 0);
    idleCheck("idle_j");

    $display("[TB] randomised bursts");
    for (int t = 0; t < 40; t++) begin
      ba = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF)) : 16'($urandom);
      nv = 5'($urandom);
      applyStimulus(1'($urandom), ba, nv, rand_pix(), 1'($urandom), 1'b0, 0);
      idleCheck($sformatf("idle_rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
